// File: rtl/gpo_if.sv
// CSR bus bundle shared by the bus master and the gpo slave.
// csr_we is a single-cycle strobe that the slave always accepts (implicit ready); csr_do is valid one cycle after csr_a.
interface gpo_if;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;

  modport master (
    output csr_a,
    output csr_di,
    output csr_we,
    input  csr_do
  );

  modport slave (
    input  csr_a,
    input  csr_di,
    input  csr_we,
    output csr_do
  );
endinterface

// File: rtl/gpo.sv
// General-purpose outputs: static level register plus timed self-clearing pulses
// that invert the level of selected outputs for DURATION*PRESCALE clk cycles.
module gpo #(
  parameter logic [4:0] BASE_ADDR = 5'd0,
  parameter int         NUM_GPIOS = 8,
  parameter int         PRESCALE  = 32,
  parameter logic [7:0] OUT_RESET = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gpo_if.slave                 csr,
  output logic [NUM_GPIOS-1:0] out,
  output logic                 dbg_state
);

  localparam int         PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [4:0] PULSE_ADDR = BASE_ADDR + 5'd1;
  localparam logic [4:0] DUR_ADDR   = BASE_ADDR + 5'd2;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e                 state, state_n;
  logic [NUM_GPIOS-1:0]   out_reg, out_reg_n;
  logic [NUM_GPIOS-1:0]   pulse_act, pulse_n;
  logic [7:0]             duration, duration_n;
  logic [PW-1:0]          presc, presc_n;
  logic [7:0]             ticks, ticks_n;
  logic [7:0]             rd_data;

  logic                   wr_out, wr_pulse, wr_dur;
  logic [NUM_GPIOS-1:0]   wr_bits;
  logic                   start, wrap, expire;

  assign wr_out   = csr.csr_we && (csr.csr_a == BASE_ADDR);
  assign wr_pulse = csr.csr_we && (csr.csr_a == PULSE_ADDR);
  assign wr_dur   = csr.csr_we && (csr.csr_a == DUR_ADDR);
  assign wr_bits  = csr.csr_di[NUM_GPIOS-1:0];

  // A start needs both nonzero bits and a nonzero duration; it outranks expiry.
  assign start  = wr_pulse && (|wr_bits) && (duration != 8'd0);
  assign wrap   = (state == BUSY) && (presc == PRESC_MAX);
  assign expire = wrap && (ticks == 8'd1);

  always_comb begin
    out_reg_n  = wr_out ? wr_bits : out_reg;
    duration_n = wr_dur ? csr.csr_di : duration;
    state_n    = state;
    pulse_n    = pulse_act;
    presc_n    = presc;
    ticks_n    = ticks;
    if (start) begin
      state_n = BUSY;
      pulse_n = pulse_act | wr_bits;
      presc_n = '0;
      ticks_n = duration;
    end else if (state == BUSY) begin
      if (expire) begin
        state_n = IDLE;
        pulse_n = '0;
        presc_n = '0;
        ticks_n = 8'd0;
      end else if (wrap) begin
        presc_n = '0;
        ticks_n = ticks - 8'd1;
      end else begin
        presc_n = presc + PW'(1);
      end
    end else begin
      pulse_n = '0;
      presc_n = '0;
      ticks_n = 8'd0;
    end
  end

  // Read mux sees the pre-write register values, so read-after-write returns old data.
  always_comb begin
    rd_data = 8'h00;
    if (csr.csr_a == BASE_ADDR) begin
      rd_data[NUM_GPIOS-1:0] = out_reg;
    end else if (csr.csr_a == PULSE_ADDR) begin
      rd_data[NUM_GPIOS-1:0] = pulse_act;
    end else if (csr.csr_a == DUR_ADDR) begin
      rd_data = duration;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_reg    <= OUT_RESET[NUM_GPIOS-1:0];
      pulse_act  <= '0;
      duration   <= 8'h00;
      presc      <= '0;
      ticks      <= 8'd0;
      out        <= OUT_RESET[NUM_GPIOS-1:0];
      csr.csr_do <= 8'h00;
    end else begin
      state      <= state_n;
      out_reg    <= out_reg_n;
      pulse_act  <= pulse_n;
      duration   <= duration_n;
      presc      <= presc_n;
      ticks      <= ticks_n;
      out        <= out_reg_n ^ pulse_n;
      csr.csr_do <= rd_data;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_gpo.sv
// Bench for gpo: register vector table with read scoreboard, then pulse timing sequences.
module tb_gpo;

  localparam int P = 4;
  localparam int D = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] out_pins;
  logic       dbg_state;

  gpo_if bus ();

  gpo #(
    .BASE_ADDR (5'd0),
    .NUM_GPIOS (8),
    .PRESCALE  (P),
    .OUT_RESET (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .csr       (bus.slave),
    .out       (out_pins),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  typedef struct {
    logic       we;
    logic [4:0] a;
    logic [7:0] di;
    logic [7:0] exp_do;
    logic [7:0] exp_out;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // scoreboard pops one expected read value per edge that had a read in flight
  task automatic tick();
    logic [7:0] e;
    string      t;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, bus.csr_do, e);
    end
  endtask

  // driver tasks
  task automatic drive(input logic we, input logic [4:0] a, input logic [7:0] di);
    bus.csr_we = we;
    bus.csr_a  = a;
    bus.csr_di = di;
  endtask

  task automatic idle();
    drive(1'b0, 5'h1F, 8'h00);
  endtask

  task automatic csr_write(input logic [4:0] a, input logic [7:0] d);
    drive(1'b1, a, d);
    tick();
    idle();
  endtask

  task automatic csr_read(input logic [4:0] a, input logic [7:0] exp, input string name);
    drive(1'b0, a, 8'h00);
    exp_q.push_back(exp);
    tag_q.push_back(name);
    tick();
    idle();
  endtask

  task automatic hold_check(input int n, input logic [7:0] exp, input string name);
    for (int i = 0; i < n; i++) begin
      tick();
      check(name, out_pins, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 5'd0,  8'h3C, 8'hA5, 8'h3C};
    vecs[1]  = '{1'b0, 5'd0,  8'h00, 8'h3C, 8'h3C};
    vecs[2]  = '{1'b1, 5'd2,  8'h07, 8'h00, 8'h3C};
    vecs[3]  = '{1'b0, 5'd2,  8'h00, 8'h07, 8'h3C};
    vecs[4]  = '{1'b0, 5'd1,  8'h00, 8'h00, 8'h3C};
    vecs[5]  = '{1'b0, 5'd3,  8'h00, 8'h00, 8'h3C};
    vecs[6]  = '{1'b0, 5'h1F, 8'hFF, 8'h00, 8'h3C};
    vecs[7]  = '{1'b0, 5'd0,  8'hFF, 8'h3C, 8'h3C};
    vecs[8]  = '{1'b1, 5'd5,  8'hFF, 8'h00, 8'h3C};
    vecs[9]  = '{1'b0, 5'd0,  8'h00, 8'h3C, 8'h3C};
    vecs[10] = '{1'b1, 5'd1,  8'h00, 8'h00, 8'h3C};
    vecs[11] = '{1'b0, 5'd1,  8'h00, 8'h00, 8'h3C};
    vecs[12] = '{1'b1, 5'd2,  8'h00, 8'h07, 8'h3C};
    vecs[13] = '{1'b1, 5'd1,  8'hFF, 8'h00, 8'h3C};
    vecs[14] = '{1'b0, 5'd1,  8'h00, 8'h00, 8'h3C};
    vecs[15] = '{1'b0, 5'd2,  8'h00, 8'h00, 8'h3C};

    // reset held low
    rst_n = 1'b0;
    idle();
    tick();
    check("rst_out", out_pins, 8'hA5);
    check("rst_do", bus.csr_do, 8'h00);
    check("rst_state", {7'd0, dbg_state}, 8'h00);
    csr_read(5'd1, 8'h00, "rst_rd_pulse");
    csr_read(5'd2, 8'h00, "rst_rd_dur");
    rst_n = 1'b1;
    tick();
    check("rel_out", out_pins, 8'hA5);
    csr_read(5'd1, 8'h00, "rel_rd_pulse");
    csr_read(5'd2, 8'h00, "rel_rd_dur");
    check("rel_out2", out_pins, 8'hA5);

    // register table
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].we, vecs[i].a, vecs[i].di);
      exp_q.push_back(vecs[i].exp_do);
      tag_q.push_back($sformatf("vec%0d_do", i));
      tick();
      idle();
      check($sformatf("vec%0d_out", i), out_pins, vecs[i].exp_out);
    end
    check("vec_state", {7'd0, dbg_state}, 8'h00);

    // pulse setup: OUT=0, DURATION=3, PRESCALE=4 -> 12 cycles
    csr_write(5'd0, 8'h00);
    csr_write(5'd2, 8'(D));
    check("setup_out", out_pins, 8'h00);

    // basic pulse with a mid-pulse PULSE read
    csr_write(5'd1, 8'h01);
    check("basic_start", out_pins, 8'h01);
    for (int k = 1; k < D * P; k++) begin
      if (k == 5) begin
        drive(1'b0, 5'd1, 8'h00);
        exp_q.push_back(8'h01);
        tag_q.push_back("basic_rd_mid");
      end
      tick();
      idle();
      check("basic_hold", out_pins, 8'h01);
    end
    hold_check(1, 8'h00, "basic_end");
    csr_read(5'd1, 8'h00, "basic_rd_after");
    check("basic_idle", {7'd0, dbg_state}, 8'h00);

    // restart at cycle 8 with another bit
    csr_write(5'd1, 8'h01);
    check("rs_start", out_pins, 8'h01);
    hold_check(7, 8'h01, "rs_first");
    csr_write(5'd1, 8'h02);
    check("rs_restart", out_pins, 8'h03);
    hold_check(D * P - 1, 8'h03, "rs_hold");
    hold_check(1, 8'h00, "rs_end");

    // zero-data PULSE write while busy does not extend
    csr_write(5'd1, 8'h01);
    hold_check(4, 8'h01, "zero_a");
    csr_write(5'd1, 8'h00);
    check("zero_w", out_pins, 8'h01);
    hold_check(6, 8'h01, "zero_b");
    hold_check(1, 8'h00, "zero_end");

    // OUT write during pulse: inversion rides on the new level
    csr_write(5'd1, 8'h01);
    hold_check(2, 8'h01, "ow_a");
    csr_write(5'd0, 8'h01);
    check("ow_w", out_pins, 8'h00);
    hold_check(8, 8'h00, "ow_b");
    hold_check(1, 8'h01, "ow_end");
    csr_write(5'd0, 8'h00);
    check("ow_restore", out_pins, 8'h00);

    // restart on the expiry edge wins and keeps the old bit
    csr_write(5'd1, 8'h01);
    hold_check(D * P - 1, 8'h01, "ex_a");
    csr_write(5'd1, 8'h02);
    check("ex_w", out_pins, 8'h03);
    check("ex_busy", {7'd0, dbg_state}, 8'h01);
    hold_check(D * P - 1, 8'h03, "ex_b");
    hold_check(1, 8'h00, "ex_end");

    // reset mid-pulse
    csr_write(5'd1, 8'h01);
    hold_check(4, 8'h01, "mr_a");
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_out", out_pins, 8'hA5);
    check("mr_do", bus.csr_do, 8'h00);
    check("mr_state", {7'd0, dbg_state}, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("mr_rel", out_pins, 8'hA5);
    csr_read(5'd1, 8'h00, "mr_rd_pulse");
    csr_read(5'd2, 8'h00, "mr_rd_dur");
    hold_check(2 * D * P, 8'hA5, "mr_quiet");
    check("mr_idle", {7'd0, dbg_state}, 8'h00);
    check("sb_empty", 8'(exp_q.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
